spn_cipher_core: RTL and testbench
==================================

// Module: spn_cipher_core
// PURPOSE
//  Iterative SPN block cipher engine with valid/ready handshakes on both sides: one round per clock.
//  Widths and round count are parametrised.
//  Sits behind spn_if-style command signals (opcode/data_in/symmetric_secret_key -> data_out/status).
//  Adds flow control and multi-cycle rounds; key and data are latched at accept.
// PARAMETERS
//  DW      16  block width in bits; multiple of 4, >= 8
//  KW      32  key width in bits; KW >= DW (elaboration $error otherwise)
//  ROUNDS  3   SPN rounds, 1..15
// PORTS
//  clk                   in   1      clock, rising edge
//  rst_n                 in   1      asynchronous reset, active-low
//  in_valid              in   1      command present
//  in_ready              out  1      core can accept (high only in IDLE)
//  opcode                in   2      00 nop, 01 enc, 10 dec, 11 undefined
//  data_in               in   DW     plaintext / ciphertext
//  symmetric_secret_key  in   KW     secret key
//  out_valid             out  1      result present; held until out_ready
//  out_ready             in   1      downstream accepts result
//  data_out              out  DW     result
//  status                out  2      01 enc ok, 10 dec ok, 11 error/undefined, 00 none
//  busy                  out  1      high in RUN or DONE
//  err_count             out  8      only with SPN_ERR_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; data_out=0; status=00; busy=0; round ctr=0.
//  Round key K_r = (key rol 4*r)[DW-1:0], r=0..ROUNDS; key is the value latched at accept.
//  S: nibble-wise, 0..F -> C 5 6 B 9 0 A D 3 E F 8 4 7 1 2; S^-1 is its inverse.
//  P: bit i -> (i*DW/4) mod (DW-1) for i<DW-1; bit DW-1 fixed. P^-1 is its inverse.
//  Enc round r=1..ROUNDS: x^=K_{r-1}; x=S(x); x=P(x) if r<ROUNDS; in round ROUNDS also x^=K_ROUNDS.
//  Dec step r=ROUNDS..1: in step ROUNDS first x^=K_ROUNDS; x=P^-1(x) if r<ROUNDS; x=S^-1(x); x^=K_{r-1}.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: accept = in_valid & in_ready. Latch data, key, op.
//    op 01/10 -> RUN, ctr=1.
//    op 11 -> DONE directly: data_out=0, status=11, out_valid=1 next cycle.
//    op 00 -> consumed, stays IDLE, no output.
//   RUN: one round per edge; ctr++. After the ROUNDS-th edge -> DONE.
//    data_out = x, status = 01/10, out_valid = 1.
//   DONE: hold data_out/status/out_valid stable while out_ready=0.
//    out_valid & out_ready -> IDLE: out_valid=0, status=00; data_out holds its last value.
//  Latency: enc/dec accept at edge N -> out_valid high after edge N+ROUNDS.
//  Undefined op -> out_valid after edge N+1.
//  No overlap: in_ready=0 in RUN/DONE. Earliest next accept is the cycle after the result handshake.
//  in_valid/opcode/data/key changes while busy: ignored, no effect on the result.
//  out_ready high before out_valid: no effect.
//  rst_n low mid-RUN/DONE: in-flight op discarded, reset values immediately (async), no output.
// CONFIGURATION
//  SPN_ERR_CNT_EN defined:
//   err_count port present. 8-bit counter, +1 on each accepted opcode 11, saturates at 255.
//   Reset to 0. Not cleared by out handshake.
//  SPN_ERR_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (DW=16, KW=32)
//  1 ROUNDS=1, key=0, enc 0x0000 -> out_valid after 1 cycle; data_out=0xCCCC, status=01.
//  2 ROUNDS=1, key=0x0000FFFF, enc 0x0000 -> data_out=0xDDD2, status=01.
//    Dec 0xDDD2 with the same key -> 0x0000, status=10.
//  3 ROUNDS=3, 256 random data/key pairs: enc then dec -> original data.
//    out_valid exactly 3 cycles after each accept; output matches reference model.
//  4 out_ready held low 10 cycles in DONE -> data_out/status/out_valid stable; in_ready=0 throughout.
//    Release -> IDLE next cycle.
//  5 opcode 11 -> data_out=0, status=11 after 1 cycle.
//    opcode 00 -> no out_valid, in_ready stays 1.
//    With SPN_ERR_CNT_EN: 300 op-11 accepts -> err_count=255.
//  6 rst_n low 2 cycles mid-RUN -> all outputs at reset values during reset; no out_valid afterwards.
//    Next enc yields the correct result.

Source files
------------

// File: rtl/spn_cipher_core.sv
// rtl/spn_cipher_core.sv - iterative SPN block cipher, one round per clock, valid/ready on both sides.
// Define SPN_ERR_CNT_EN to add the saturating undefined-opcode counter (err_count port).
module spn_cipher_core #(
  parameter int DW     = 16,
  parameter int KW     = 32,
  parameter int ROUNDS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    opcode,
  input  logic [DW-1:0] data_in,
  input  logic [KW-1:0] symmetric_secret_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic [1:0]    status,
`ifdef SPN_ERR_CNT_EN
  output logic [7:0]    err_count,
`endif
  output logic          busy
);

  if (KW < DW) begin : g_bad_kw
    $error("spn_cipher_core: KW must be >= DW");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
  localparam logic [1:0] OP_ENC = 2'b01, OP_DEC = 2'b10, OP_ERR = 2'b11;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    case (n)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] n);
    case (n)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction

  function automatic logic [DW-1:0] sub_layer(input logic [DW-1:0] x, input logic inv);
    logic [DW-1:0] y;
    for (int n = 0; n < DW / 4; n++) begin
      y[4*n +: 4] = inv ? sbox_inv(x[4*n +: 4]) : sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Multiplying by DW/4 is invertible mod DW-1, so every bit below DW-1 is rewritten.
  function automatic logic [DW-1:0] perm_layer(input logic [DW-1:0] x, input logic inv);
    logic [DW-1:0] y;
    y = x;
    for (int i = 0; i < DW - 1; i++) begin
      if (inv) y[i] = x[(i * (DW / 4)) % (DW - 1)];
      else     y[(i * (DW / 4)) % (DW - 1)] = x[i];
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] round_key(input logic [KW-1:0] k, input logic [3:0] r);
    logic [2*KW-1:0] kk;
    int              s;
    s  = (4 * int'(r)) % KW;
    kk = {k, k} << s;
    return kk[KW +: DW];
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    ctr_q, ctr_d;
  logic [DW-1:0] x_q, x_d;
  logic [KW-1:0] key_q, key_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic [1:0]    status_q, status_d;
  logic [3:0]    dec_r;
  logic          last;
  logic [DW-1:0] enc_s, enc_x, dec_p, dec_x, round_x;
`ifdef SPN_ERR_CNT_EN
  logic [7:0]    err_q, err_d;
  assign err_count = err_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign data_out  = data_out_q;
  assign status    = status_q;

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    x_d        = x_q;
    key_d      = key_q;
    op_d       = op_q;
    data_out_d = data_out_q;
    status_d   = status_q;
`ifdef SPN_ERR_CNT_EN
    err_d      = err_q;
`endif
    last    = (ctr_q == 4'(ROUNDS));
    dec_r   = 4'(ROUNDS) + 4'd1 - ctr_q;
    enc_s   = sub_layer(x_q ^ round_key(key_q, ctr_q - 4'd1), 1'b0);
    enc_x   = last ? (enc_s ^ round_key(key_q, 4'(ROUNDS))) : perm_layer(enc_s, 1'b0);
    dec_p   = (dec_r == 4'(ROUNDS)) ? (x_q ^ round_key(key_q, 4'(ROUNDS))) : perm_layer(x_q, 1'b1);
    dec_x   = sub_layer(dec_p, 1'b1) ^ round_key(key_q, dec_r - 4'd1);
    round_x = (op_q == OP_DEC) ? dec_x : enc_x;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (opcode)
            OP_ENC, OP_DEC: begin
              x_d     = data_in;
              key_d   = symmetric_secret_key;
              op_d    = opcode;
              ctr_d   = 4'd1;
              state_d = ST_RUN;
            end
            // Undefined op spends one RUN cycle (as its final round) so it reports one edge after accept.
            OP_ERR: begin
              op_d    = OP_ERR;
              ctr_d   = 4'(ROUNDS);
              state_d = ST_RUN;
`ifdef SPN_ERR_CNT_EN
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (last) begin
          data_out_d = (op_q == OP_ERR) ? '0 : round_x;
          status_d   = op_q;
          ctr_d      = 4'd0;
          state_d    = ST_DONE;
        end else begin
          x_d   = round_x;
          ctr_d = ctr_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          status_d = 2'b00;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      x_q        <= '0;
      key_q      <= '0;
      op_q       <= '0;
      data_out_q <= '0;
      status_q   <= '0;
`ifdef SPN_ERR_CNT_EN
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      x_q        <= x_d;
      key_q      <= key_d;
      op_q       <= op_d;
      data_out_q <= data_out_d;
      status_q   <= status_d;
`ifdef SPN_ERR_CNT_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_spn_cipher_core.sv
// tb/tb_spn_cipher_core.sv - randomized self-checking bench for spn_cipher_core (ROUNDS=3 and ROUNDS=1 instances).
module tb_spn_cipher_core;

  localparam int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv_a = 1'b0, iv_b = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic [15:0] din = '0;
  logic [31:0] key = '0;
  logic        out_ready = 1'b0;
  logic        ir_a, ov_a, busy_a, ir_b, ov_b, busy_b;
  logic [15:0] dout_a, dout_b;
  logic [1:0]  st_a, st_b;
`ifdef SPN_ERR_CNT_EN
  logic [7:0]  ec_a, ec_b;
`endif
  logic        sel = 1'b0;
  logic        s_ir, s_ov, s_busy;
  logic [15:0] s_dout;
  logic [1:0]  s_st;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  spn_cipher_core #(.DW(16), .KW(32), .ROUNDS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .opcode(opcode),
    .data_in(din), .symmetric_secret_key(key), .out_valid(ov_a), .out_ready(out_ready),
    .data_out(dout_a), .status(st_a),
`ifdef SPN_ERR_CNT_EN
    .err_count(ec_a),
`endif
    .busy(busy_a));

  spn_cipher_core #(.DW(16), .KW(32), .ROUNDS(1)) u_dut_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .opcode(opcode),
    .data_in(din), .symmetric_secret_key(key), .out_valid(ov_b), .out_ready(out_ready),
    .data_out(dout_b), .status(st_b),
`ifdef SPN_ERR_CNT_EN
    .err_count(ec_b),
`endif
    .busy(busy_b));

  always_comb begin
    s_ir   = sel ? ir_b   : ir_a;
    s_ov   = sel ? ov_b   : ov_a;
    s_busy = sel ? busy_b : busy_a;
    s_dout = sel ? dout_b : dout_a;
    s_st   = sel ? st_b   : st_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_rk(input logic [31:0] k, input int r);
    logic [15:0] y;
    for (int j = 0; j < 16; j++) y[j] = k[((j - 4 * r) % 32 + 32) % 32];
    return y;
  endfunction

  function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
    logic [15:0] y;
    int v;
    for (int n = 0; n < 4; n++) begin
      v = int'(x[4*n +: 4]);
      if (!inv) y[4*n +: 4] = 4'(SB[v]);
      else for (int t = 0; t < 16; t++) if (SB[t] == v) y[4*n +: 4] = 4'(t);
    end
    return y;
  endfunction

  function automatic logic [15:0] m_perm(input logic [15:0] x, input bit inv);
    logic [15:0] y;
    y[15] = x[15];
    for (int i = 0; i < 15; i++) begin
      if (!inv) y[(i * 4) % 15] = x[i];
      else      y[i] = x[(i * 4) % 15];
    end
    return y;
  endfunction

  function automatic logic [15:0] m_enc(input logic [15:0] d, input logic [31:0] k, input int nr);
    logic [15:0] x = d;
    for (int r = 1; r <= nr; r++) begin
      x = m_sub(x ^ m_rk(k, r - 1), 1'b0);
      if (r < nr) x = m_perm(x, 1'b0);
      else        x = x ^ m_rk(k, nr);
    end
    return x;
  endfunction

  function automatic logic [15:0] m_dec(input logic [15:0] d, input logic [31:0] k, input int nr);
    logic [15:0] x = d;
    for (int r = nr; r >= 1; r--) begin
      if (r == nr) x = x ^ m_rk(k, nr);
      else         x = m_perm(x, 1'b1);
      x = m_sub(x, 1'b1) ^ m_rk(k, r - 1);
    end
    return x;
  endfunction

  // Issue one command, scramble inputs while busy, optionally stall the result, then hand it off.
  task automatic do_op(input logic s, input logic [1:0] op, input logic [15:0] d, input logic [31:0] k,
                       input int hold, output logic [15:0] rd, output logic [1:0] rs, output int lat);
    sel = s;
    @(negedge clk);
    check("in_ready_before", s_ir, 1);
    opcode = op; din = d; key = k;
    if (s) iv_b = 1'b1; else iv_a = 1'b1;
    @(negedge clk);
    lat = 0;
    for (int c = 0; c < 40 && !s_ov; c++) begin
      check("busy_run", s_busy, 1);
      check("in_ready_run", s_ir, 0);
      opcode = 2'($urandom); din = 16'($urandom); key = $urandom; out_ready = 1'($urandom);
      if (s) iv_b = 1'($urandom); else iv_a = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("out_valid", s_ov, 1);
    rd = s_dout; rs = s_st;
    iv_a = 1'b0; iv_b = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      opcode = 2'($urandom); din = 16'($urandom); key = $urandom;
      @(negedge clk);
      check("hold_valid", s_ov, 1);
      check("hold_data", s_dout, rd);
      check("hold_status", s_st, rs);
      check("hold_in_ready", s_ir, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", s_ov, 0);
    check("post_hs_in_ready", s_ir, 1);
    check("post_hs_status", s_st, 0);
    check("post_hs_busy", s_busy, 0);
    check("post_hs_data_hold", s_dout, rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, d, ct;
    logic [1:0]  rs;
    logic [31:0] k;
    int          lat;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {ir_a, ir_b}, 2'b11);
    check("rst_out_valid", {ov_a, ov_b}, 2'b00);
    check("rst_busy", {busy_a, busy_b}, 2'b00);
    check("rst_data", {dout_a, dout_b}, 0);
    check("rst_status", {st_a, st_b}, 0);
    rst_n = 1'b1;

    do_op(1'b1, 2'b01, 16'h0000, 32'h0, 0, rd, rs, lat);
    check("r1_enc0_data", rd, 16'hCCCC);
    check("r1_enc0_status", rs, 2'b01);
    check("r1_enc0_lat", lat, 1);
    do_op(1'b1, 2'b01, 16'h0000, 32'h0000FFFF, 0, rd, rs, lat);
    check("r1_enc1_data", rd, 16'hDDD2);
    check("r1_enc1_status", rs, 2'b01);
    do_op(1'b1, 2'b10, 16'hDDD2, 32'h0000FFFF, 0, rd, rs, lat);
    check("r1_dec1_data", rd, 16'h0000);
    check("r1_dec1_status", rs, 2'b10);
    check("r1_dec1_lat", lat, 1);

    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom); k = $urandom;
      do_op(1'b0, 2'b01, d, k, 0, ct, rs, lat);
      check("rnd_enc_data", ct, m_enc(d, k, 3));
      check("rnd_enc_status", rs, 2'b01);
      check("rnd_enc_lat", lat, 3);
      do_op(1'b0, 2'b10, ct, k, 0, rd, rs, lat);
      check("rnd_dec_data", rd, d);
      check("rnd_dec_model", rd, m_dec(ct, k, 3));
      check("rnd_dec_status", rs, 2'b10);
      check("rnd_dec_lat", lat, 3);
    end

    d = 16'($urandom); k = $urandom;
    do_op(1'b0, 2'b01, d, k, 10, rd, rs, lat);
    check("stall_data", rd, m_enc(d, k, 3));

    do_op(1'b0, 2'b11, 16'($urandom), $urandom, 2, rd, rs, lat);
    check("undef_data", rd, 0);
    check("undef_status", rs, 2'b11);
    check("undef_lat", lat, 1);

    sel = 1'b0;
    @(negedge clk);
    opcode = 2'b00; din = 16'($urandom); iv_a = 1'b1;
    @(negedge clk);
    iv_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("nop_out_valid", ov_a, 0);
      check("nop_in_ready", ir_a, 1);
      @(negedge clk);
    end

    d = 16'($urandom); k = $urandom;
    do_op(1'b0, 2'b01, d, k, 0, rd, rs, lat);
    @(negedge clk);
    opcode = 2'b10; din = 16'($urandom); key = $urandom; iv_a = 1'b1;
    @(negedge clk);
    iv_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("midrst_in_ready", ir_a, 1);
      check("midrst_out_valid", ov_a, 0);
      check("midrst_busy", busy_a, 0);
      check("midrst_data", dout_a, 0);
      check("midrst_status", st_a, 0);
`ifdef SPN_ERR_CNT_EN
      check("midrst_err_count", ec_a, 0);
`endif
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("postrst_no_valid", ov_a, 0);
    end
    d = 16'($urandom); k = $urandom;
    do_op(1'b0, 2'b01, d, k, 0, rd, rs, lat);
    check("postrst_enc_data", rd, m_enc(d, k, 3));
    check("postrst_enc_lat", lat, 3);

`ifdef SPN_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      do_op(1'b0, 2'b11, 16'($urandom), $urandom, 0, rd, rs, lat);
      if (i == 9) check("err_count_10", ec_a, 10);
    end
    check("err_count_sat", ec_a, 255);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
